// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis scorer: thermometer score codes, FSM states
// and the single-point scoring rule applied to a (point winner, other player) pair.
`timescale 1ns/1ps
package tennis_pkg;

  localparam logic [3:0] SC_0   = 4'b0000;
  localparam logic [3:0] SC_15  = 4'b0001;
  localparam logic [3:0] SC_30  = 4'b0011;
  localparam logic [3:0] SC_40  = 4'b0111;
  localparam logic [3:0] SC_ADV = 4'b1111;

  typedef enum logic {
    PLAY     = 1'b0,
    WIN_HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic       win;
    logic [3:0] w_next;
    logic [3:0] l_next;
  } step_t;

  // w is the score of the player who took the point, l the opponent's.
  function automatic step_t score_point(input logic [3:0] w, input logic [3:0] l);
    step_t s;
    s.win    = 1'b0;
    s.w_next = w;
    s.l_next = l;
    if (l == SC_ADV) begin
      s.w_next = SC_40;
      s.l_next = SC_40;
    end else if (w == SC_ADV || (w == SC_40 && l != SC_40)) begin
      s.win    = 1'b1;
      s.w_next = SC_ADV;
    end else if (w == SC_40) begin
      s.w_next = SC_ADV;
    end else begin
      s.w_next = {w[2:0], 1'b1};
    end
    return s;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-flop synchroniser, debounce, rising edge.
`timescale 1ns/1ps
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic          r_pulse;
  logic [CW-1:0] r_cnt;

  // The counter only advances while the synchronised level disagrees with the
  // accepted level, so any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta  <= i_btn;
      r_sync  <= r_meta;
      r_pulse <= 1'b0;
      if (r_sync == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync;
        r_pulse  <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/tennis_score_fsm.sv
// One-game tennis scorer: conditioned point buttons drive a PLAY / WIN_HOLD FSM
// with thermometer score outputs and saturating games-won counters.
`timescale 1ns/1ps
module tennis_score_fsm
  import tennis_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int GAME_W          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_a,
  input  logic              btn_b,
  output logic [3:0]        score_a,
  output logic [3:0]        score_b,
  output logic              win_a,
  output logic              win_b,
  output logic [GAME_W-1:0] games_a,
  output logic [GAME_W-1:0] games_b
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  logic [1:0] w_btn;
  logic [1:0] w_pt;
  step_t      w_step_a;
  step_t      w_step_b;

  state_t            r_state;
  logic [3:0]        r_score_a;
  logic [3:0]        r_score_b;
  logic              r_win_a;
  logic              r_win_b;
  logic [GAME_W-1:0] r_games_a;
  logic [GAME_W-1:0] r_games_b;
  logic [HCW-1:0]    r_hold_cnt;

  assign w_btn = {btn_b, btn_a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cond
      btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (w_btn[gi]),
        .o_pulse(w_pt[gi])
      );
    end
  endgenerate

  assign w_step_a = score_point(r_score_a, r_score_b);
  assign w_step_b = score_point(r_score_b, r_score_a);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PLAY;
      r_score_a  <= SC_0;
      r_score_b  <= SC_0;
      r_win_a    <= 1'b0;
      r_win_b    <= 1'b0;
      r_games_a  <= '0;
      r_games_b  <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        PLAY: begin
          // A point pair arriving in the same cycle is ambiguous and dropped.
          if (w_pt[0] && !w_pt[1]) begin
            r_score_a <= w_step_a.w_next;
            r_score_b <= w_step_a.l_next;
            if (w_step_a.win) begin
              r_state    <= WIN_HOLD;
              r_win_a    <= 1'b1;
              r_hold_cnt <= '0;
            end
          end else if (w_pt[1] && !w_pt[0]) begin
            r_score_b <= w_step_b.w_next;
            r_score_a <= w_step_b.l_next;
            if (w_step_b.win) begin
              r_state    <= WIN_HOLD;
              r_win_b    <= 1'b1;
              r_hold_cnt <= '0;
            end
          end
        end
        WIN_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            if (r_win_a && r_games_a != '1) r_games_a <= r_games_a + 1'b1;
            if (r_win_b && r_games_b != '1) r_games_b <= r_games_b + 1'b1;
            r_score_a <= SC_0;
            r_score_b <= SC_0;
            r_win_a   <= 1'b0;
            r_win_b   <= 1'b0;
            r_state   <= PLAY;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign score_a = r_score_a;
  assign score_b = r_score_b;
  assign win_a   = r_win_a;
  assign win_b   = r_win_b;
  assign games_a = r_games_a;
  assign games_b = r_games_b;

endmodule

// File: tb/tb_tennis_score_fsm.sv
// Scoreboard bench for tennis_score_fsm with short debounce and hold periods.
`timescale 1ns/1ps
module tb_tennis_score_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic [3:0] score_a, score_b, games_a, games_b;
  logic       win_a, win_b;

  typedef struct packed {
    logic [3:0] sa;
    logic [3:0] sb;
    logic       wa;
    logic       wb;
    logic [3:0] ga;
    logic [3:0] gb;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  tennis_score_fsm #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .GAME_W         (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_a  (btn_a),
    .btn_b  (btn_b),
    .score_a(score_a),
    .score_b(score_b),
    .win_a  (win_a),
    .win_b  (win_b),
    .games_a(games_a),
    .games_b(games_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic obs_t snap();
    obs_t o;
    o.sa = score_a; o.sb = score_b; o.wa = win_a; o.wb = win_b;
    o.ga = games_a; o.gb = games_b;
    return o;
  endfunction

  function automatic obs_t mk(input logic [3:0] sa, input logic [3:0] sb, input logic wa,
                              input logic wb, input logic [3:0] ga, input logic [3:0] gb);
    obs_t o;
    o.sa = sa; o.sb = sb; o.wa = wa; o.wb = wb; o.ga = ga; o.gb = gb;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("sa=%b sb=%b wa=%b wb=%b ga=%0d gb=%0d", o.sa, o.sb, o.wa, o.wb, o.ga, o.gb);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press for 10 cycles, sample mid-press (point already applied), release and settle.
  task automatic press(input logic a, input logic b, output obs_t mid);
    btn_a = a; btn_b = b;
    step(10);
    mid = snap();
    btn_a = 1'b0; btn_b = 1'b0;
    step(10);
  endtask

  task automatic push(input obs_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    obs_t obs, e; string nm;
    rst_n = 1'b0;
    step(2);
    push(mk(4'h0, 4'h0, 0, 0, 0, 0), "reset_state");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_straight_game();
    obs_t obs, e; string nm;
    logic [3:0] sc [3] = '{4'b0001, 4'b0011, 4'b0111};
    int n, cnt;
    for (int i = 0; i < 3; i++) begin
      push(mk(sc[i], 4'h0, 0, 0, 0, 0), $sformatf("straight_pt%0d", i + 1));
      press(1'b1, 1'b0, obs);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
      else $display("ok   %s %s", nm, fmt(obs));
    end
    // Fourth press is held right through the hold: must win once and not score on exit.
    btn_a = 1'b1;
    n = 0;
    while (!win_a && n < 20) begin step(1); n++; end
    push(mk(4'hF, 4'h0, 1, 0, 0, 0), "straight_win");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    cnt = 0;
    while (win_a && cnt < 50) begin cnt++; step(1); end
    checks++;
    if (cnt != 8) begin errors++; $display("FAIL hold_length got %0d cycles want 8", cnt); end
    else $display("ok   hold_length %0d cycles", cnt);
    step(10);
    btn_a = 1'b0;
    step(10);
    push(mk(4'h0, 4'h0, 0, 0, 1, 0), "straight_after_hold");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_deuce_advantage();
    obs_t obs, e; string nm;
    logic       pa  [10] = '{1, 1, 1, 0, 0, 0, 1, 0, 1, 1};
    logic [3:0] esa [10] = '{4'h1, 4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'h7, 4'hF, 4'hF};
    logic [3:0] esb [10] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};
    for (int i = 0; i < 10; i++) begin
      push(mk(esa[i], esb[i], (i == 9), 0, 1, 0), $sformatf("deuce_step%0d", i + 1));
      press(pa[i], !pa[i], obs);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
      else $display("ok   %s %s", nm, fmt(obs));
    end
    push(mk(4'h0, 4'h0, 0, 0, 2, 0), "deuce_after_hold");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_bounce_and_hold();
    obs_t obs, e; string nm;
    for (int i = 0; i < 10; i++) begin
      btn_a = !btn_a;
      step(2);
    end
    btn_a = 1'b1;
    step(100);
    push(mk(4'h1, 4'h0, 0, 0, 2, 0), "bounce_one_point");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    btn_a = 1'b0;
    step(10);
    btn_a = 1'b1;
    step(3);
    btn_a = 1'b0;
    step(12);
    push(mk(4'h1, 4'h0, 0, 0, 2, 0), "short_pulse_ignored");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_simultaneous();
    obs_t obs, e; string nm;
    push(mk(4'h1, 4'h0, 0, 0, 2, 0), "simultaneous_discarded");
    press(1'b1, 1'b1, obs);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_hold_lockout();
    obs_t obs, e; string nm;
    int n;
    push(mk(4'h3, 4'h0, 0, 0, 2, 0), "lockout_pt30");
    press(1'b1, 1'b0, obs);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    push(mk(4'h7, 4'h0, 0, 0, 2, 0), "lockout_pt40");
    press(1'b1, 1'b0, obs);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    btn_a = 1'b1;
    n = 0;
    while (!win_a && n < 20) begin step(1); n++; end
    btn_a = 1'b0;
    btn_b = 1'b1;
    step(4);
    push(mk(4'hF, 4'h0, 1, 0, 2, 0), "lockout_mid_hold");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    step(8);
    btn_b = 1'b0;
    step(10);
    push(mk(4'h0, 4'h0, 0, 0, 3, 0), "lockout_b_ignored");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_player_b();
    obs_t obs, e; string nm;
    logic [3:0] sc [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      push(mk(4'h0, sc[i], 0, (i == 3), 3, 0), $sformatf("b_game_pt%0d", i + 1));
      press(1'b0, 1'b1, obs);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
      else $display("ok   %s %s", nm, fmt(obs));
    end
    push(mk(4'h0, 4'h0, 0, 0, 3, 1), "b_game_after_hold");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_saturation();
    obs_t obs, e; string nm;
    for (int w = 0; w < 12; w++)
      for (int p = 0; p < 4; p++) press(1'b1, 1'b0, obs);
    push(mk(4'h0, 4'h0, 0, 0, 15, 1), "games_reach_15");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    for (int p = 0; p < 3; p++) press(1'b1, 1'b0, obs);
    push(mk(4'hF, 4'h0, 1, 0, 15, 1), "sat_win");
    press(1'b1, 1'b0, obs);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    push(mk(4'h0, 4'h0, 0, 0, 15, 1), "games_saturated");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  task automatic test_reset_mid();
    obs_t obs, e; string nm;
    int n;
    press(1'b1, 1'b0, obs);
    press(1'b1, 1'b0, obs);
    push(mk(4'h3, 4'h1, 0, 0, 15, 1), "reset_mid_30_15");
    press(1'b0, 1'b1, obs);
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    // Reset between clock edges: outputs must clear before the next rising edge.
    #2 rst_n = 1'b0;
    #1;
    push(mk(4'h0, 4'h0, 0, 0, 0, 0), "async_reset_in_play");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    for (int p = 0; p < 3; p++) press(1'b1, 1'b0, obs);
    btn_a = 1'b1;
    n = 0;
    while (!win_a && n < 20) begin step(1); n++; end
    step(2);
    #2 rst_n = 1'b0;
    btn_a = 1'b0;
    #1;
    push(mk(4'h0, 4'h0, 0, 0, 0, 0), "async_reset_in_hold");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
    @(negedge clk);
    rst_n = 1'b1;
    step(20);
    push(mk(4'h0, 4'h0, 0, 0, 0, 0), "no_win_credited");
    obs = snap();
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s got %s want %s", nm, fmt(obs), fmt(e)); end
    else $display("ok   %s %s", nm, fmt(obs));
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_straight_game();
    test_deuce_advantage();
    test_bounce_and_hold();
    test_simultaneous();
    test_hold_lockout();
    test_player_b();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
